uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
Frame-level controller that sits directly behind the UART byte receiver. It consumes the receiver's per-byte strobes (rx_data/rx_done/rx_err) and assembles command frames. Payload bytes go to an external byte RAM through a simple write port. Each validated command is presented on a valid/ready interface to the register/command layer. Malformed, truncated or stalled frames are aborted, and each abort raises a one-cycle error pulse.

Parameters:
CLK_HZ, 200_000_000, system clock frequency in Hz
BAUD, 9600, line rate; used only to derive the timeout default
MAX_LEN, 64, maximum payload length in bytes (1..255)
AW, $clog2(MAX_LEN), payload RAM address width
TIMEOUT_CLKS, CLK_HZ/BAUD*20, inter-byte timeout in clk cycles (about 2 character times)
SYNC_BYTE, 8'hA5, frame start marker

Ports:
clk  in  1  system clock
nrst  in  1  reset; synchronous, active-low
rx_data  in  8  received byte; valid when rx_done=1
rx_done  in  1  one-cycle strobe, byte received with a good stop bit
rx_err  in  1  one-cycle strobe, framing error (bad stop bit); never coincides with rx_done
pay_we  out  1  payload RAM write enable
pay_addr  out  AW  payload RAM address
pay_wdata  out  8  payload RAM write data
cmd_valid  out  1  a complete, checksum-correct frame is available
cmd_ready  in  1  consumer accepts the frame
cmd_code  out  8  command byte of the frame
cmd_len  out  8  payload length of the frame
err_chk  out  1  pulse: checksum mismatch
err_len  out  1  pulse: LEN > MAX_LEN
err_timeout  out  1  pulse: inter-byte timeout inside a frame
err_frame  out  1  pulse: rx_err inside a frame
err_overrun  out  1  pulse: byte dropped while a command is pending
busy  out  1  state != IDLE

Behaviour:
- Frame format: SYNC, CMD, LEN, PAYLOAD[0..LEN-1], CHK. The frame is valid when (CMD+LEN+sum(PAYLOAD)+CHK) mod 256 == 0.
- Checksum accumulator: 8-bit, wraps modulo 256, cleared on SYNC.
- States and transitions:
  - IDLE: rx_done with rx_data==SYNC_BYTE goes to CMD. Any other byte is ignored. rx_err is ignored, with no pulse.
  - CMD: rx_done latches cmd_code, adds the byte to the sum, goes to LEN.
  - LEN: rx_done with byte > MAX_LEN pulses err_len and goes to IDLE. Byte == 0 latches cmd_len and goes to CHK. Otherwise latch cmd_len, clear the byte index and go to DATA.
  - DATA: each rx_done adds the byte to the sum. On the next cycle pay_we=1, pay_addr=index, pay_wdata=byte. The index increments after each byte; after the byte at index LEN-1, go to CHK.
  - CHK: rx_done with a good sum goes to HOLD and asserts cmd_valid on the next cycle. A bad sum pulses err_chk and goes to IDLE.
  - HOLD: cmd_valid=1. cmd_code and cmd_len stay stable, and RAM is not written. cmd_ready=1 makes the handshake; cmd_valid drops and the state is IDLE on the next cycle. Any rx_done in HOLD, including the handshake cycle, pulses err_overrun and the byte is discarded; a SYNC byte does not start a frame. rx_err in HOLD is ignored.
- Timeout:
  - Counter active in CMD, LEN, DATA and CHK only.
  - Cleared on SYNC and on every rx_done.
  - When it reaches TIMEOUT_CLKS-1 without a byte: pulse err_timeout, go to IDLE.
- rx_err in CMD, LEN, DATA or CHK: pulse err_frame, go to IDLE.
- Priority within one cycle: rx_err, then rx_done, then timeout.
- Error pulses and pay_we are registered, one cycle wide, and occur one cycle after the triggering strobe or timeout.
- Latency: last CHK rx_done to cmd_valid=1 is 1 cycle.
- Reset (nrst=0 at a clk edge) returns to IDLE from any state, mid-frame or mid-HOLD.
  - Outputs cleared: cmd_valid, pay_we, all err_* and busy go to 0; cmd_code, cmd_len, pay_addr and pay_wdata go to 0.
  - The counters and the checksum accumulator are also cleared.
  - A frame that was pending is lost.

Test Plan:
1. Bytes A5 10 03 11 22 33 87, cmd_ready=1. Expect pay_we ×3 with addr/data 0/11, 1/22, 2/33. Expect cmd_valid 1 cycle after the 87 byte with cmd_code=10, cmd_len=3, accepted in 1 cycle, no err_*.
2. A5 20 00 E0 (zero-length) with cmd_ready=0 for 100 cycles, then byte A5 -> no pay_we; cmd_valid held with code 20 and len 0; err_overrun pulse for the A5 byte. Then assert cmd_ready -> IDLE.
3. A5 10 03 11 22 33 88 (bad CHK) -> err_chk pulse, no cmd_valid. A following good frame is accepted normally.
4. With MAX_LEN=64: A5 10 41 -> err_len pulse, busy=0. Next, A5 10 02 11 then silence for TIMEOUT_CLKS -> err_timeout pulse exactly TIMEOUT_CLKS-1 cycles after the last rx_done, busy=0.
5. A5 10 02 11 then an rx_err strobe -> err_frame pulse, IDLE. Separately, nrst=0 for one cycle during DATA -> all outputs 0, and a fresh frame decodes correctly with addresses restarting at 0.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// Frame-level controller behind the UART byte receiver.
// Assembles SYNC/CMD/LEN/PAYLOAD/CHK frames, streams payload bytes to an
// external byte RAM, presents checked commands on a valid/ready port and
// raises one-cycle error pulses for every aborted frame.
module uart_rx_frame_ctrl #(
    parameter int unsigned CLK_HZ       = 200_000_000,
    parameter int unsigned BAUD         = 9600,
    parameter int unsigned MAX_LEN      = 64,
    parameter int unsigned AW           = $clog2(MAX_LEN),
    parameter int unsigned TIMEOUT_CLKS = CLK_HZ / BAUD * 20,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          rx_err,
    output logic          pay_we,
    output logic [AW-1:0] pay_addr,
    output logic [7:0]    pay_wdata,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [7:0]    cmd_code,
    output logic [7:0]    cmd_len,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic          err_frame,
    output logic          err_overrun,
    output logic          busy
);

    localparam int unsigned TW        = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_LEN,
        S_DATA,
        S_CHK,
        S_HOLD
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [7:0]    sum;
    logic [7:0]    sum_next;
    logic [AW-1:0] idx;
    logic [TW-1:0] tmo_cnt;

    logic          in_frame;
    logic          done_ok;
    logic          is_sync;
    logic          last_byte;
    logic          tmo_hit;

    logic          we_req;
    logic          chk_req;
    logic          len_req;
    logic          tmo_req;
    logic          frame_req;
    logic          ovr_req;

    assign in_frame  = (state == S_CMD) || (state == S_LEN) ||
                       (state == S_DATA) || (state == S_CHK);
    assign done_ok   = rx_done && !rx_err;
    assign is_sync   = done_ok && (rx_data == SYNC_BYTE);
    assign sum_next  = sum + rx_data;
    assign last_byte = (8'(idx) == (cmd_len - 8'd1));
    // The counter reaches TIMEOUT_CLKS-1 on the same edge that registers the
    // pulse, so the hit is detected one count early.
    assign tmo_hit   = in_frame && !rx_err && !rx_done &&
                       (tmo_cnt == TW'(TIMEOUT_CLKS - 2));

    // State register
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: rx_err beats rx_done beats timeout inside a frame
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (is_sync) state_next = S_CMD;
            end
            S_CMD: begin
                if (rx_err || tmo_hit) state_next = S_IDLE;
                else if (rx_done)      state_next = S_LEN;
            end
            S_LEN: begin
                if (rx_err || tmo_hit) state_next = S_IDLE;
                else if (rx_done) begin
                    if (rx_data > MAX_LEN_B) state_next = S_IDLE;
                    else if (rx_data == 8'd0) state_next = S_CHK;
                    else state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (rx_err || tmo_hit)        state_next = S_IDLE;
                else if (rx_done && last_byte) state_next = S_CHK;
            end
            S_CHK: begin
                if (rx_err || tmo_hit) state_next = S_IDLE;
                else if (rx_done)      state_next = (sum_next == 8'd0) ? S_HOLD : S_IDLE;
            end
            S_HOLD: begin
                if (cmd_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Output decode: live status plus requests for the registered pulses
    always_comb begin
        cmd_valid = (state == S_HOLD);
        busy      = (state != S_IDLE);
        we_req    = 1'b0;
        chk_req   = 1'b0;
        len_req   = 1'b0;
        tmo_req   = tmo_hit;
        frame_req = in_frame && rx_err;
        ovr_req   = 1'b0;
        case (state)
            S_LEN:   len_req = done_ok && (rx_data > MAX_LEN_B);
            S_DATA:  we_req  = done_ok;
            S_CHK:   chk_req = done_ok && (sum_next != 8'd0);
            S_HOLD:  ovr_req = rx_done;
            default: ;
        endcase
    end

    // Datapath: checksum, command latches, payload index, timeout, pulses
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sum         <= '0;
            idx         <= '0;
            tmo_cnt     <= '0;
            cmd_code    <= '0;
            cmd_len     <= '0;
            pay_we      <= 1'b0;
            pay_addr    <= '0;
            pay_wdata   <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            err_frame   <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            pay_we      <= we_req;
            err_chk     <= chk_req;
            err_len     <= len_req;
            err_timeout <= tmo_req;
            err_frame   <= frame_req;
            err_overrun <= ovr_req;

            if (we_req) begin
                pay_addr  <= idx;
                pay_wdata <= rx_data;
            end

            if (state == S_IDLE && is_sync) begin
                sum <= '0;
            end else if (done_ok && (state == S_CMD || state == S_LEN || state == S_DATA)) begin
                sum <= sum_next;
            end

            if (state == S_CMD && done_ok) begin
                cmd_code <= rx_data;
            end

            if (state == S_LEN && done_ok && rx_data <= MAX_LEN_B) begin
                cmd_len <= rx_data;
                idx     <= '0;
            end else if (state == S_DATA && done_ok) begin
                idx <= idx + AW'(1);
            end

            if (rx_done || !in_frame) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + TW'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: nominal frames, zero-length frame
// with back-pressure and overrun, checksum/length/timeout/framing aborts,
// and a mid-frame reset. Expected values are hand-computed constants.
module tb_uart_rx_frame_ctrl;

    localparam int unsigned T_CLKS = 40;
    localparam int unsigned AW     = 6;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_done = 1'b0;
    logic          rx_err = 1'b0;
    logic          pay_we;
    logic [AW-1:0] pay_addr;
    logic [7:0]    pay_wdata;
    logic          cmd_valid;
    logic          cmd_ready = 1'b1;
    logic [7:0]    cmd_code;
    logic [7:0]    cmd_len;
    logic          err_chk;
    logic          err_len;
    logic          err_timeout;
    logic          err_frame;
    logic          err_overrun;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;

    // pulse counters, sampled at each rising edge
    int ev_we  = 0;
    int ev_err = 0;

    uart_rx_frame_ctrl #(
        .MAX_LEN      (64),
        .TIMEOUT_CLKS (T_CLKS),
        .SYNC_BYTE    (8'hA5)
    ) dut (
        .clk         (clk),
        .nrst        (nrst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rx_err      (rx_err),
        .pay_we      (pay_we),
        .pay_addr    (pay_addr),
        .pay_wdata   (pay_wdata),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_code    (cmd_code),
        .cmd_len     (cmd_len),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .err_frame   (err_frame),
        .err_overrun (err_overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pay_we) ev_we <= ev_we + 1;
        if (err_chk || err_len || err_timeout || err_frame || err_overrun)
            ev_err <= ev_err + 1;
    end

    initial begin
        #200us;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // one rx_done strobe; returns 1 time unit after the edge that samples it
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic send_gap(input logic [7:0] b);
        send(b);
        idle(2);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".outs"}, {pay_we, cmd_valid, busy, err_chk, err_len,
                              err_timeout, err_frame, err_overrun}, 32'h0);
        check({tag, ".code"}, 32'(cmd_code), 32'h0);
        check({tag, ".len"},  32'(cmd_len), 32'h0);
        check({tag, ".addr"}, 32'(pay_addr), 32'h0);
        check({tag, ".wdata"}, 32'(pay_wdata), 32'h0);
    endtask

    initial begin
        int we0;
        int err0;
        logic early;

        // reset
        nrst = 1'b0;
        idle(2);
        check_all_zero("reset");
        nrst = 1'b1;
        idle(2);

        // 1: nominal 3-byte frame, consumer always ready
        we0 = ev_we; err0 = ev_err;
        send_gap(8'hA5);
        check("t1.busy", 32'(busy), 32'h1);
        send_gap(8'h10);
        send_gap(8'h03);
        send(8'h11);
        check("t1.we0", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd0, 8'h11});
        tick();
        check("t1.we_drop", 32'(pay_we), 32'h0);
        idle(1);
        send(8'h22);
        check("t1.we1", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd1, 8'h22});
        idle(2);
        send(8'h33);
        check("t1.we2", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd2, 8'h33});
        idle(2);
        check("t1.no_valid_yet", 32'(cmd_valid), 32'h0);
        send(8'h87);
        check("t1.valid", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'h10, 8'h03});
        tick();
        check("t1.accepted", {cmd_valid, busy}, 2'b00);
        idle(1);
        check("t1.we_count", 32'(ev_we - we0), 32'd3);
        check("t1.no_err", 32'(ev_err - err0), 32'd0);

        // 2: zero-length frame held under back-pressure, overrun in HOLD
        cmd_ready = 1'b0;
        we0 = ev_we;
        send_gap(8'hA5);
        send_gap(8'h20);
        send_gap(8'h00);
        send(8'hE0);
        check("t2.valid", {cmd_valid, cmd_code, cmd_len}, {1'b1, 8'h20, 8'h00});
        idle(100);
        check("t2.held", {cmd_valid, busy, cmd_code, cmd_len}, {2'b11, 8'h20, 8'h00});
        send(8'hA5);
        check("t2.overrun", {err_overrun, cmd_valid, cmd_code}, {2'b11, 8'h20});
        tick();
        check("t2.overrun_drop", {err_overrun, cmd_valid, busy}, 3'b011);
        // byte arriving on the handshake cycle is also an overrun
        cmd_ready = 1'b1;
        send(8'hA5);
        check("t2.handshake", {err_overrun, cmd_valid, busy}, 3'b100);
        idle(2);
        check("t2.still_idle", 32'(busy), 32'h0);
        check("t2.no_we", 32'(ev_we - we0), 32'd0);

        // 3: bad checksum, then a good single-byte frame
        send_gap(8'hA5);
        send_gap(8'h10);
        send_gap(8'h03);
        send_gap(8'h11);
        send_gap(8'h22);
        send_gap(8'h33);
        send(8'h88);
        check("t3.err_chk", {err_chk, cmd_valid, busy}, 3'b100);
        tick();
        check("t3.err_chk_drop", 32'(err_chk), 32'h0);
        send_gap(8'hA5);
        send_gap(8'h30);
        send_gap(8'h01);
        send(8'h44);
        check("t3.we", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd0, 8'h44});
        idle(2);
        send(8'h8B);
        check("t3.valid", {cmd_valid, cmd_code, cmd_len, err_chk}, {1'b1, 8'h30, 8'h01, 1'b0});
        tick();
        check("t3.accepted", 32'(cmd_valid), 32'h0);

        // 4: length limit, then inter-byte timeout
        send_gap(8'hA5);
        send_gap(8'h10);
        send(8'h41);
        check("t4.err_len", {err_len, busy}, 2'b10);
        tick();
        check("t4.err_len_drop", 32'(err_len), 32'h0);
        send_gap(8'hA5);
        send_gap(8'h10);
        send(8'h40);
        check("t4.len_max_ok", {err_len, busy}, 2'b01);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        check("t4.abort", {err_frame, busy}, 2'b10);
        idle(1);
        send_gap(8'hA5);
        send_gap(8'h10);
        send_gap(8'h02);
        send(8'h11);
        check("t4.we", {pay_we, pay_wdata}, {1'b1, 8'h11});
        early = 1'b0;
        for (int k = 1; k <= int'(T_CLKS) - 2; k++) begin
            tick();
            if (err_timeout || !busy) early = 1'b1;
        end
        check("t4.no_early_tmo", 32'(early), 32'h0);
        tick();
        check("t4.timeout", {err_timeout, busy}, 2'b10);
        tick();
        check("t4.timeout_drop", 32'(err_timeout), 32'h0);

        // 5: rx_err inside a frame, then reset during payload
        send_gap(8'hA5);
        send_gap(8'h10);
        send_gap(8'h02);
        send_gap(8'h11);
        rx_err = 1'b1;
        tick();
        rx_err = 1'b0;
        check("t5.err_frame", {err_frame, busy}, 2'b10);
        tick();
        check("t5.err_frame_drop", 32'(err_frame), 32'h0);
        send_gap(8'hA5);
        send_gap(8'h10);
        send_gap(8'h03);
        send_gap(8'h11);
        send(8'h22);
        check("t5.pre_reset_we", {pay_we, 2'b00, pay_addr}, {1'b1, 2'b00, 6'd1});
        nrst = 1'b0;
        tick();
        check_all_zero("t5.reset");
        nrst = 1'b1;
        idle(2);
        check("t5.idle_after_reset", 32'(busy), 32'h0);
        send_gap(8'hA5);
        send_gap(8'h40);
        send_gap(8'h02);
        send(8'h55);
        check("t5.we0", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd0, 8'h55});
        idle(2);
        send(8'h66);
        check("t5.we1", {pay_we, 2'b00, pay_addr, pay_wdata}, {1'b1, 2'b00, 6'd1, 8'h66});
        idle(2);
        send(8'h03);
        check("t5.valid", {cmd_valid, cmd_code, cmd_len, err_chk}, {1'b1, 8'h40, 8'h02, 1'b0});
        tick();
        check("t5.accepted", {cmd_valid, busy}, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
